// File: rtl/mest_pro_alu_seq.sv
// ---------------------------------------------------------------------------
// mest_pro_alu_seq
//
// Multi-cycle execute unit for the MEST Pro core, between decode and
// writeback. Single-cycle ALU ops complete in the accepting clock; MUL runs
// as an iterative shift-add over DATA_W cycles and returns a 2*DATA_W
// product. Results and flags are registered and only change on a done edge.
//
// Ports
//   clk          rising-edge clock
//   i_reset_n    asynchronous active-low reset
//   i_start      operation request, accepted only while o_busy=0
//   i_flush      synchronous abort of an in-flight MUL; also drops i_start
//   i_op         operation code (0..11 legal, 12..15 illegal)
//   i_a, i_b     operands
//   o_busy       multiply in progress
//   o_done       one-cycle pulse, result/flags valid
//   o_result     result, or low half of product
//   o_result_hi  high half of product, 0 for non-MUL
//   o_carry      carry/borrow flag (also the carry-in for ADC)
//   o_zero       zero flag
//   o_neg        MSB of o_result
//   o_ovf        signed overflow (ADD/ADC/SUB only)
//
// State   | Meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for i_start; non-MUL ops complete here in one edge
// S_MUL   | shift-add multiply in progress, one multiplier bit per edge
// ---------------------------------------------------------------------------
module mest_pro_alu_seq #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_flush,
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result,
    output logic [DATA_W-1:0] o_result_hi,
    output logic              o_carry,
    output logic              o_zero,
    output logic              o_neg,
    output logic              o_ovf
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_ADC = 4'd9;
    localparam logic [3:0] OP_ROL = 4'd10;
    localparam logic [3:0] OP_ROR = 4'd11;

    localparam int MSB = DATA_W - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                  accept;
    logic                  is_mul_op;
    logic                  mul_last;

    logic [2*DATA_W-1:0]   mcand_q;
    logic [2*DATA_W-1:0]   acc_q;
    logic [2*DATA_W-1:0]   acc_step;
    logic [DATA_W-1:0]     mplier_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [DATA_W:0]       a_ext;
    logic [DATA_W:0]       b_ext;
    logic [DATA_W:0]       arith;
    logic [DATA_W-1:0]     alu_res;
    logic                  alu_carry;
    logic                  alu_ovf;

    // Flush has priority over start, so a start in a flush cycle is dropped.
    assign accept    = i_start && !i_flush && (state_q == S_IDLE);
    assign is_mul_op = (i_op == OP_MUL);
    assign mul_last  = (state_q == S_MUL) && (cnt_q == LAST_CNT);
    assign o_busy    = (state_q == S_MUL);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul_op) begin
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (i_flush || mul_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------ single-cycle ALU
    assign a_ext = {1'b0, i_a};
    assign b_ext = {1'b0, i_b};

    always_comb begin
        arith     = '0;
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (i_op)
            OP_ADD: begin
                arith     = a_ext + b_ext;
                alu_res   = arith[DATA_W-1:0];
                alu_carry = arith[DATA_W];
                alu_ovf   = (i_a[MSB] == i_b[MSB]) && (alu_res[MSB] != i_a[MSB]);
            end
            OP_ADC: begin
                // Carry-in is the registered carry of the last completed op.
                arith     = a_ext + b_ext + {{DATA_W{1'b0}}, o_carry};
                alu_res   = arith[DATA_W-1:0];
                alu_carry = arith[DATA_W];
                alu_ovf   = (i_a[MSB] == i_b[MSB]) && (alu_res[MSB] != i_a[MSB]);
            end
            OP_SUB: begin
                // Bit DATA_W of the extended difference is the borrow.
                arith     = a_ext - b_ext;
                alu_res   = arith[DATA_W-1:0];
                alu_carry = arith[DATA_W];
                alu_ovf   = (i_a[MSB] != i_b[MSB]) && (alu_res[MSB] != i_a[MSB]);
            end
            OP_AND: alu_res = i_a & i_b;
            OP_OR:  alu_res = i_a | i_b;
            OP_XOR: alu_res = i_a ^ i_b;
            OP_NOT: alu_res = ~i_a;
            OP_SHR: begin
                alu_res   = {1'b0, i_a[DATA_W-1:1]};
                alu_carry = i_a[0];
            end
            OP_SHL: begin
                alu_res   = {i_a[DATA_W-2:0], 1'b0};
                alu_carry = i_a[MSB];
            end
            OP_ROL: begin
                alu_res   = {i_a[DATA_W-2:0], i_a[MSB]};
                alu_carry = i_a[MSB];
            end
            OP_ROR: begin
                alu_res   = {i_a[0], i_a[DATA_W-1:1]};
                alu_carry = i_a[0];
            end
            // MUL is handled by the iterative path; 12..15 are illegal and
            // report a zero result with only the zero flag set.
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
                alu_ovf   = 1'b0;
            end
        endcase
    end

    // --------------------------------------------------- shift-add multiply
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (accept && is_mul_op) begin
            mcand_q  <= {{DATA_W{1'b0}}, i_a};
            mplier_q <= i_b;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if ((state_q == S_MUL) && !i_flush) begin
            acc_q    <= acc_step;
            mcand_q  <= {mcand_q[2*DATA_W-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[DATA_W-1:1]};
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    // ---------------------------------------------------- registered outputs
    // The final product is taken from acc_step so the last partial product
    // is folded in on the same edge that raises o_done.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_done      <= 1'b0;
            o_result    <= '0;
            o_result_hi <= '0;
            o_carry     <= 1'b0;
            o_zero      <= 1'b0;
            o_neg       <= 1'b0;
            o_ovf       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (accept && !is_mul_op) begin
                o_done      <= 1'b1;
                o_result    <= alu_res;
                o_result_hi <= '0;
                o_carry     <= alu_carry;
                o_zero      <= (alu_res == '0);
                o_neg       <= alu_res[MSB];
                o_ovf       <= alu_ovf;
            end else if (mul_last && !i_flush) begin
                o_done      <= 1'b1;
                o_result    <= acc_step[DATA_W-1:0];
                o_result_hi <= acc_step[2*DATA_W-1:DATA_W];
                o_carry     <= (acc_step[2*DATA_W-1:DATA_W] != '0);
                o_zero      <= (acc_step == '0);
                o_neg       <= acc_step[MSB];
                o_ovf       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mest_pro_alu_seq.sv
module tb_mest_pro_alu_seq;

    localparam int DATA_W = 8;
    localparam int CNT_W  = $clog2(DATA_W) + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_ADC = 4'd9;
    localparam logic [3:0] OP_ROL = 4'd10;
    localparam logic [3:0] OP_ROR = 4'd11;

    logic              clk;
    logic              i_reset_n;
    logic              i_start;
    logic              i_flush;
    logic [3:0]        i_op;
    logic [DATA_W-1:0] i_a;
    logic [DATA_W-1:0] i_b;
    logic              o_busy;
    logic              o_done;
    logic [DATA_W-1:0] o_result;
    logic [DATA_W-1:0] o_result_hi;
    logic              o_carry;
    logic              o_zero;
    logic              o_neg;
    logic              o_ovf;

    int checks = 0;
    int errors = 0;

    mest_pro_alu_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .i_reset_n   (i_reset_n),
        .i_start     (i_start),
        .i_flush     (i_flush),
        .i_op        (i_op),
        .i_a         (i_a),
        .i_b         (i_b),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_result    (o_result),
        .o_result_hi (o_result_hi),
        .o_carry     (o_carry),
        .o_zero      (o_zero),
        .o_neg       (o_neg),
        .o_ovf       (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one start at a negedge; returns 1ns after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        i_start = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        issue(OP_ADD, 8'hFF, 8'h02);
        checks++; if (o_result !== 8'h01 || o_carry !== 1'b1) begin errors++;
            $display("FAIL pre_reset_add: result=%h carry=%b want 01/1", o_result, o_carry); end
        issue(OP_MUL, 8'h10, 8'h10);
        repeat (3) @(posedge clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin errors++;
            $display("FAIL reset_busy_done: busy=%b done=%b want 0/0", o_busy, o_done); end
        checks++; if (o_result !== 8'h00 || o_result_hi !== 8'h00) begin errors++;
            $display("FAIL reset_result: result=%h hi=%h want 00/00", o_result, o_result_hi); end
        checks++; if ({o_carry, o_zero, o_neg, o_ovf} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags: cznv=%b want 0000", {o_carry, o_zero, o_neg, o_ovf}); end
        @(negedge clk);
        i_reset_n = 1'b1;
        issue(OP_ADC, 8'h01, 8'h01);
        checks++; if (o_done !== 1'b1 || o_result !== 8'h02 || o_carry !== 1'b0) begin errors++;
            $display("FAIL reset_adc: done=%b result=%h carry=%b want 1/02/0", o_done, o_result, o_carry); end
    endtask

    task automatic test_add_adc();
        issue(OP_ADD, 8'hFF, 8'h01);
        checks++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin errors++;
            $display("FAIL add_done: done=%b busy=%b want 1/0", o_done, o_busy); end
        checks++; if (o_result !== 8'h00 || {o_carry, o_zero, o_neg, o_ovf} !== 4'b1100) begin errors++;
            $display("FAIL add_ff_01: result=%h cznv=%b want 00/1100", o_result, {o_carry, o_zero, o_neg, o_ovf}); end
        @(posedge clk); #1;
        checks++; if (o_done !== 1'b0 || o_result !== 8'h00) begin errors++;
            $display("FAIL add_pulse_hold: done=%b result=%h want 0/00", o_done, o_result); end
        issue(OP_ADC, 8'h10, 8'h20);
        checks++; if (o_result !== 8'h31 || o_carry !== 1'b0 || o_zero !== 1'b0) begin errors++;
            $display("FAIL adc_carry_in: result=%h carry=%b zero=%b want 31/0/0", o_result, o_carry, o_zero); end
    endtask

    task automatic test_sub();
        issue(OP_SUB, 8'h80, 8'h01);
        checks++; if (o_result !== 8'h7F || {o_carry, o_zero, o_neg, o_ovf} !== 4'b0001) begin errors++;
            $display("FAIL sub_80_01: result=%h cznv=%b want 7f/0001", o_result, {o_carry, o_zero, o_neg, o_ovf}); end
        issue(OP_SUB, 8'h01, 8'h02);
        checks++; if (o_result !== 8'hFF || {o_carry, o_zero, o_neg, o_ovf} !== 4'b1010) begin errors++;
            $display("FAIL sub_01_02: result=%h cznv=%b want ff/1010", o_result, {o_carry, o_zero, o_neg, o_ovf}); end
    endtask

    task automatic test_logic_shift();
        issue(OP_AND, 8'hF0, 8'h3C);
        checks++; if (o_result !== 8'h30 || o_carry !== 1'b0) begin errors++;
            $display("FAIL and: result=%h carry=%b want 30/0", o_result, o_carry); end
        issue(OP_OR, 8'hF0, 8'h0F);
        checks++; if (o_result !== 8'hFF || o_neg !== 1'b1) begin errors++;
            $display("FAIL or: result=%h neg=%b want ff/1", o_result, o_neg); end
        issue(OP_SHL, 8'h81, 8'h00);
        checks++; if (o_result !== 8'h02 || o_carry !== 1'b1 || o_ovf !== 1'b0) begin errors++;
            $display("FAIL shl: result=%h carry=%b ovf=%b want 02/1/0", o_result, o_carry, o_ovf); end
        issue(OP_SHR, 8'h01, 8'h00);
        checks++; if (o_result !== 8'h00 || o_carry !== 1'b1 || o_zero !== 1'b1) begin errors++;
            $display("FAIL shr: result=%h carry=%b zero=%b want 00/1/1", o_result, o_carry, o_zero); end
        issue(OP_NOT, 8'h0F, 8'h00);
        checks++; if (o_result !== 8'hF0 || o_carry !== 1'b0 || o_neg !== 1'b1) begin errors++;
            $display("FAIL not: result=%h carry=%b neg=%b want f0/0/1", o_result, o_carry, o_neg); end
        issue(OP_ROR, 8'h01, 8'h00);
        checks++; if (o_result !== 8'h80 || o_carry !== 1'b1 || o_neg !== 1'b1) begin errors++;
            $display("FAIL ror: result=%h carry=%b neg=%b want 80/1/1", o_result, o_carry, o_neg); end
    endtask

    task automatic test_mul();
        int busy_cnt;
        int done_edge;
        issue(OP_MUL, 8'hFF, 8'hFF);
        busy_cnt  = o_busy ? 1 : 0;
        done_edge = 0;
        checks++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin errors++;
            $display("FAIL mul_accept: busy=%b done=%b want 1/0", o_busy, o_done); end
        for (int e = 2; e <= 20; e++) begin
            if (e == 4) begin
                i_start = 1'b1;
                i_op    = OP_ADD;
                i_a     = 8'h01;
                i_b     = 8'h01;
            end
            @(posedge clk); #1;
            i_start = 1'b0;
            if (o_busy) busy_cnt++;
            if (o_done) begin
                done_edge = e;
                break;
            end
        end
        checks++; if (done_edge !== 9 || busy_cnt !== 8) begin errors++;
            $display("FAIL mul_latency: done_edge=%0d busy_cycles=%0d want 9/8", done_edge, busy_cnt); end
        checks++; if (o_result !== 8'h01 || o_result_hi !== 8'hFE) begin errors++;
            $display("FAIL mul_ff_ff: result=%h hi=%h want 01/fe", o_result, o_result_hi); end
        checks++; if ({o_carry, o_zero, o_neg, o_ovf} !== 4'b1000) begin errors++;
            $display("FAIL mul_flags: cznv=%b want 1000", {o_carry, o_zero, o_neg, o_ovf}); end

        // New MUL started in the done cycle must be accepted.
        i_start = 1'b1;
        i_op    = OP_MUL;
        i_a     = 8'h03;
        i_b     = 8'h05;
        @(posedge clk); #1;
        i_start = 1'b0;
        checks++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin errors++;
            $display("FAIL mul_in_done_cycle: busy=%b done=%b want 1/0", o_busy, o_done); end
        done_edge = 0;
        for (int e = 2; e <= 20; e++) begin
            @(posedge clk); #1;
            if (o_done) begin
                done_edge = e;
                break;
            end
        end
        checks++; if (done_edge !== 9 || o_result !== 8'h0F || o_result_hi !== 8'h00 || o_carry !== 1'b0) begin errors++;
            $display("FAIL mul_03_05: done_edge=%0d result=%h hi=%h carry=%b want 9/0f/00/0",
                     done_edge, o_result, o_result_hi, o_carry); end
    endtask

    task automatic test_flush();
        bit seen_done;
        issue(OP_MUL, 8'h12, 8'h34);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++; if (o_busy !== 1'b1) begin errors++;
            $display("FAIL flush_busy4: busy=%b want 1", o_busy); end
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        checks++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin errors++;
            $display("FAIL flush_abort: busy=%b done=%b want 0/0", o_busy, o_done); end
        seen_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (o_done) seen_done = 1'b1;
        end
        checks++; if (seen_done !== 1'b0 || o_result !== 8'h0F || o_result_hi !== 8'h00 || o_carry !== 1'b0) begin errors++;
            $display("FAIL flush_hold: done_seen=%b result=%h hi=%h carry=%b want 0/0f/00/0",
                     seen_done, o_result, o_result_hi, o_carry); end

        // Start together with flush is dropped.
        @(negedge clk);
        i_start = 1'b1;
        i_flush = 1'b1;
        i_op    = OP_ADD;
        i_a     = 8'h11;
        i_b     = 8'h22;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_flush = 1'b0;
        checks++; if (o_done !== 1'b0 || o_result !== 8'h0F) begin errors++;
            $display("FAIL flush_start: done=%b result=%h want 0/0f", o_done, o_result); end

        issue(OP_ROL, 8'h81, 8'h00);
        checks++; if (o_done !== 1'b1 || o_result !== 8'h03 || o_carry !== 1'b1) begin errors++;
            $display("FAIL rol_81: done=%b result=%h carry=%b want 1/03/1", o_done, o_result, o_carry); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        i_start = 1'b1;
        i_op    = OP_XOR;
        i_a     = 8'hAA;
        i_b     = 8'hAA;
        @(posedge clk); #1;
        checks++; if (o_done !== 1'b1 || o_result !== 8'h00 || o_zero !== 1'b1 || o_carry !== 1'b0) begin errors++;
            $display("FAIL b2b_xor: done=%b result=%h zero=%b carry=%b want 1/00/1/0", o_done, o_result, o_zero, o_carry); end
        i_op = 4'd13;
        i_a  = 8'h5A;
        i_b  = 8'hC3;
        @(posedge clk); #1;
        i_start = 1'b0;
        checks++; if (o_done !== 1'b1 || o_result !== 8'h00 || o_result_hi !== 8'h00) begin errors++;
            $display("FAIL b2b_illegal: done=%b result=%h hi=%h want 1/00/00", o_done, o_result, o_result_hi); end
        checks++; if ({o_carry, o_zero, o_neg, o_ovf} !== 4'b0100) begin errors++;
            $display("FAIL illegal_flags: cznv=%b want 0100", {o_carry, o_zero, o_neg, o_ovf}); end
        @(posedge clk); #1;
        checks++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin errors++;
            $display("FAIL b2b_end: done=%b busy=%b want 0/0", o_done, o_busy); end
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_start   = 1'b0;
        i_flush   = 1'b0;
        i_op      = 4'd0;
        i_a       = '0;
        i_b       = '0;
        #1;
        checks++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_result !== 8'h00 || o_carry !== 1'b0) begin errors++;
            $display("FAIL initial_reset: busy=%b done=%b result=%h carry=%b want 0/0/00/0",
                     o_busy, o_done, o_result, o_carry); end
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;

        test_reset();
        test_add_adc();
        test_sub();
        test_logic_shift();
        test_mul();
        test_flush();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mest_pro_alu_seq.md
# mest_pro_alu_seq

Parametrised, multi-cycle execute unit for the MEST Pro core.
- Accepts one operation per start strobe and computes all single-cycle ALU ops in one clock.
- Runs multiply as an iterative shift-add over DATA_W cycles and returns a full 2×DATA_W product.
- Reports registered carry/zero/negative/overflow flags with a busy/done handshake.
- Sits between decode and writeback.

## Interface

Clocking is decided: one clock `clk`; reset `i_reset_n` is asynchronous and active-low.

Parameters:
- DATA_W, 8, operand/result width (≥4).
- CNT_W, $clog2(DATA_W)+1, multiply iteration counter width.

Ports:
- clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  operation request; accepted only when o_busy=0.
- i_flush  in  1  synchronous abort of any in-flight operation.
- i_op  in  4  operation code.
- i_a  in  DATA_W  operand A.
- i_b  in  DATA_W  operand B.
- o_busy  out  1  multiply in progress.
- o_done  out  1  one-cycle pulse; result/flags valid.
- o_result  out  DATA_W  result, or low half of product.
- o_result_hi  out  DATA_W  high half of product; 0 for non-MUL.
- o_carry  out  1  carry/borrow flag.
- o_zero  out  1  zero flag.
- o_neg  out  1  MSB of o_result.
- o_ovf  out  1  signed overflow.

## Operation

Op codes:
- 0 ADD: a+b.
- 1 SUB: a−b.
- 2 AND, 3 OR, 4 XOR.
- 5 SHR: a>>1.
- 6 SHL: a<<1.
- 7 NOT: ~a.
- 8 MUL: a×b, unsigned.
- 9 ADC: a+b+stored carry.
- 10 ROL: a rotated left by 1.
- 11 ROR: a rotated right by 1.
- 12–15 illegal: result 0, hi 0, zero=1, other flags 0, done pulses normally.

Arithmetic is performed at DATA_W+1 bits.
- ADD/ADC carry = bit DATA_W of the sum.
- SUB carry = borrow (1 iff a<b unsigned).
- ovf = signed overflow for ADD/ADC/SUB; 0 for all other ops.
- SHL/ROL carry = old a[DATA_W−1]; SHR/ROR carry = old a[0]; logic ops carry = 0.
- MUL carry = (o_result_hi≠0); zero = full product==0.
- All other ops: zero = (o_result==0).

FSM states:
- IDLE
  - start with a non-MUL op: compute and register at the accepting edge, pulse done, stay IDLE.
  - start with MUL: load multiplicand, multiplier and an accumulator of 2×DATA_W bits, counter=0, go to MUL.
- MUL: each edge adds the shifted multiplicand if the current multiplier bit is 1, shifts, counter+1. On the DATA_W-th edge after accept, register product and flags, pulse done, return to IDLE.

Rules:
- i_start while busy is ignored; no queuing.
- i_flush: in MUL, returns to IDLE at the next edge with busy=0, no done, outputs and stored carry unchanged.
- i_flush and i_start in the same cycle: flush wins, start is dropped.
- Outputs and flags change only on a done edge and hold between operations.
- ADC uses the carry from the last completed op; it is unaffected by flushed ops.

## Timing

Reset: all outputs 0, stored carry 0, state IDLE, counter 0; the reset is asynchronous and may occur mid-multiply. The first edge after deassertion can accept a start.

Latency, counted in rising edges including the accepting edge:
- Non-MUL ops: 1. o_done is high in the cycle after the accept edge; o_busy stays 0.
- MUL: DATA_W+1. o_busy is high for DATA_W cycles after the accept edge and falls in the same cycle o_done rises.

Throughput:
- Non-MUL ops: back-to-back, one per cycle.
- MUL: a new start is accepted in the cycle o_done is high.

o_done is high for exactly one cycle per completed op.

## Test plan

DATA_W=8 for all scenarios.
- Reset asserted mid-MUL → all outputs 0 immediately; busy 0; a subsequent ADC 0x01+0x01 gives 0x02, proving stored carry was cleared.
- ADD 0xFF+0x01 → result 0x00, carry 1, zero 1, ovf 0, neg 0; done 1 cycle after start. Follow with ADC 0x10+0x20 → 0x31, carry 0.
- SUB 0x80−0x01 → 0x7F, carry 0, ovf 1, neg 0. SUB 0x01−0x02 → 0xFF, carry 1, neg 1.
- MUL 0xFF×0xFF → hi 0xFE, result 0x01, carry 1, zero 0.
  - busy high exactly 8 cycles; done on the 9th edge counting the accept edge.
  - A start issued while busy is ignored; the next MUL is accepted in the done cycle.
- MUL 0x12×0x34 flushed on its 4th busy cycle → no done pulse, busy 0 next cycle, outputs hold previous values. Then ROL 0x81 → 0x03, carry 1.
- Back-to-back non-MUL ops XOR 0xAA^0xAA then illegal op 13 on consecutive cycles:
  - XOR → 0x00, zero 1.
  - op 13 → result 0, zero 1.
  - Two done pulses on consecutive cycles.
